// File: rtl/tcb_arb.sv
// Round-robin arbiter sharing one TCB subordinate among PN managers.
// Requests pass through combinationally; responses are routed back after DLY cycles.
module tcb_arb #(
    parameter int PN  = 2,
    parameter int AW  = 22,
    parameter int DW  = 32,
    parameter int BW  = DW/8,
    parameter int DLY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PN-1:0]      s_vld,
    input  logic [PN-1:0]      s_wen,
    input  logic [PN*AW-1:0]   s_adr,
    input  logic [PN*BW-1:0]   s_ben,
    input  logic [PN*DW-1:0]   s_wdt,
    output logic [PN-1:0]      s_rdy,
    output logic [PN*DW-1:0]   s_rdt,
    output logic [PN-1:0]      s_err,
    output logic               m_vld,
    output logic               m_wen,
    output logic [AW-1:0]      m_adr,
    output logic [BW-1:0]      m_ben,
    output logic [DW-1:0]      m_wdt,
    input  logic               m_rdy,
    input  logic [DW-1:0]      m_rdt,
    input  logic               m_err
);

    localparam int IW = $clog2(PN);

    logic [IW-1:0]  r_ptr;
    logic           r_lck;
    logic [IW-1:0]  r_lgn;
    logic [DLY-1:0] r_pv;
    logic [IW-1:0]  r_pi [DLY];

    logic [IW-1:0]  w_rrSel;
    logic           w_found;
    logic [IW-1:0]  w_sel;
    logic           w_any;
    logic           w_xfer;

    // First requester at or after the priority pointer, wrapping modulo PN.
    always_comb begin
        w_rrSel = r_ptr;
        w_found = 1'b0;
        for (int k = 0; k < PN; k++) begin
            if (!w_found && s_vld[(int'(r_ptr) + k) % PN]) begin
                w_rrSel = IW'((int'(r_ptr) + k) % PN);
                w_found = 1'b1;
            end
        end
    end

    assign w_sel  = r_lck ? r_lgn : w_rrSel;
    assign w_any  = (|s_vld) | r_lck;
    assign m_vld  = w_any & s_vld[w_sel] & ~rst;
    assign w_xfer = m_vld & m_rdy;

    always_comb begin
        m_wen = 1'b0;
        m_adr = '0;
        m_ben = '0;
        m_wdt = '0;
        if (m_vld) begin
            m_wen = s_wen[w_sel];
            m_adr = s_adr[int'(w_sel)*AW +: AW];
            m_ben = s_ben[int'(w_sel)*BW +: BW];
            m_wdt = s_wdt[int'(w_sel)*DW +: DW];
        end
    end

    always_comb begin
        s_rdy = '0;
        for (int i = 0; i < PN; i++) begin
            s_rdy[i] = w_xfer & (w_sel == IW'(i));
        end
    end

    // A stalled request pins the grant so the holder cannot be preempted mid-handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            r_lck <= 1'b0;
            r_lgn <= '0;
        end else begin
            r_lck <= m_vld & ~m_rdy;
            if (m_vld & ~m_rdy) begin
                r_lgn <= w_sel;
            end
            if (w_xfer) begin
                r_ptr <= (w_sel == IW'(PN-1)) ? '0 : w_sel + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv <= '0;
            for (int k = 0; k < DLY; k++) begin
                r_pi[k] <= '0;
            end
        end else begin
            r_pv[0] <= w_xfer;
            r_pi[0] <= w_sel;
            for (int k = 1; k < DLY; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pi[k] <= r_pi[k-1];
            end
        end
    end

    // The last stage lines up with the subordinate's response.
    always_comb begin
        s_rdt = '0;
        s_err = '0;
        if (r_pv[DLY-1]) begin
            s_rdt[int'(r_pi[DLY-1])*DW +: DW] = m_rdt;
            s_err[r_pi[DLY-1]]                = m_err;
        end
    end

endmodule

// File: tb/tb_tcb_arb.sv
// Self-checking bench for tcb_arb: directed scenarios followed by randomized
// traffic compared against a transaction-level round-robin model.
module tb_tcb_arb;

    localparam int PN  = 4;
    localparam int AW  = 22;
    localparam int DW  = 32;
    localparam int BW  = DW/8;
    localparam int DLY = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [PN-1:0]    s_vld;
    logic [PN-1:0]    s_wen;
    logic [PN*AW-1:0] s_adr;
    logic [PN*BW-1:0] s_ben;
    logic [PN*DW-1:0] s_wdt;
    logic [PN-1:0]    s_rdy;
    logic [PN*DW-1:0] s_rdt;
    logic [PN-1:0]    s_err;
    logic             m_vld;
    logic             m_wen;
    logic [AW-1:0]    m_adr;
    logic [BW-1:0]    m_ben;
    logic [DW-1:0]    m_wdt;
    logic             m_rdy;
    logic [DW-1:0]    m_rdt;
    logic             m_err;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        int due;
        int idx;
    } resp_t;

    tcb_arb #(.PN(PN), .AW(AW), .DW(DW), .BW(BW), .DLY(DLY)) dut (
        .clk(clk), .rst(rst),
        .s_vld(s_vld), .s_wen(s_wen), .s_adr(s_adr), .s_ben(s_ben), .s_wdt(s_wdt),
        .s_rdy(s_rdy), .s_rdt(s_rdt), .s_err(s_err),
        .m_vld(m_vld), .m_wen(m_wen), .m_adr(m_adr), .m_ben(m_ben), .m_wdt(m_wdt),
        .m_rdy(m_rdy), .m_rdt(m_rdt), .m_err(m_err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        s_vld = '0;
        s_wen = '0;
        s_adr = '0;
        s_ben = '0;
        s_wdt = '0;
        m_rdy = 1'b0;
        m_rdt = '0;
        m_err = 1'b0;
    endtask

    task automatic applyStimulus(input int i, input logic wen, input logic [AW-1:0] adr,
                                 input logic [BW-1:0] ben, input logic [DW-1:0] wdt);
        s_vld[i]           = 1'b1;
        s_wen[i]           = wen;
        s_adr[i*AW +: AW]  = adr;
        s_ben[i*BW +: BW]  = ben;
        s_wdt[i*DW +: DW]  = wdt;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int rrPick(input int start, input logic [PN-1:0] v);
        for (int k = 0; k < PN; k++) begin
            if (v[(start + k) % PN]) return (start + k) % PN;
        end
        return -1;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        s_vld = '1;
        m_rdy = 1'b1;
        m_rdt = 32'hFFFF_FFFF;
        m_err = 1'b1;
        #1;
        testsRun++;
        if (m_vld !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_m_vld: got %b expected 0", m_vld);
        end
        testsRun++;
        if (s_rdy !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_s_rdy: got %b expected 0", s_rdy);
        end
        testsRun++;
        if (s_rdt !== '0 || s_err !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_resp: got rdt %h err %b expected 0", s_rdt, s_err);
        end
        @(negedge clk);
        rst = 1'b0;
        idle();
    endtask

    task automatic test_single();
        doReset();
        applyStimulus(1, 1'b0, 22'h000010, 4'hF, 32'h0);
        m_rdy = 1'b1;
        #1;
        testsRun++;
        if (s_rdy !== 4'b0010 || m_adr !== 22'h000010 || m_wen !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL single_req: got rdy %b adr %h wen %b expected 0010 000010 0", s_rdy, m_adr, m_wen);
        end
        @(negedge clk);
        idle();
        m_rdt = 32'hDEADBEEF;
        #1;
        testsRun++;
        if (s_rdt !== '0) begin
            testsFailed++;
            $display("[TB] FAIL single_early: got %h expected 0", s_rdt);
        end
        @(negedge clk);
        #1;
        testsRun++;
        if (s_rdt[1*DW +: DW] !== 32'hDEADBEEF || s_rdt[0 +: DW] !== '0 || s_err !== '0) begin
            testsFailed++;
            $display("[TB] FAIL single_resp: got %h err %b expected slice1 deadbeef", s_rdt, s_err);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_contention();
        doReset();
        for (int i = 0; i < PN; i++) applyStimulus(i, 1'b1, AW'(22'h100 + i), 4'h3, 32'hA0 + i);
        m_rdy = 1'b1;
        for (int c = 0; c < 2*PN + 1; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            testsRun++;
            if (s_rdy !== PN'(1 << (c % PN)) || m_adr !== AW'(22'h100 + (c % PN))) begin
                testsFailed++;
                $display("[TB] FAIL contention_c%0d: got rdy %b adr %h expected grant %0d", c, s_rdy, m_adr, c % PN);
            end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_backpressure();
        doReset();
        applyStimulus(2, 1'b1, 22'h2A2A2, 4'h1, 32'h22);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) applyStimulus(0, 1'b0, 22'h00555, 4'hF, 32'h0);
            m_rdy = 1'b0;
            #1;
            testsRun++;
            if (m_adr !== 22'h2A2A2 || s_rdy !== '0 || m_vld !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL bp_hold_c%0d: got adr %h rdy %b vld %b expected 2a2a2 0000 1", c, m_adr, s_rdy, m_vld);
            end
        end
        @(negedge clk);
        m_rdy = 1'b1;
        #1;
        testsRun++;
        if (s_rdy !== 4'b0100) begin
            testsFailed++;
            $display("[TB] FAIL bp_release: got %b expected 0100", s_rdy);
        end
        @(negedge clk);
        s_vld[2] = 1'b0;
        #1;
        testsRun++;
        if (s_rdy !== 4'b0001 || m_adr !== 22'h00555) begin
            testsFailed++;
            $display("[TB] FAIL bp_next: got rdy %b adr %h expected 0001 00555", s_rdy, m_adr);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_back_to_back();
        doReset();
        applyStimulus(1, 1'b0, 22'h111, 4'hF, 32'h0);
        m_rdy = 1'b1;
        #1;
        testsRun++;
        if (s_rdy !== 4'b0010) begin
            testsFailed++;
            $display("[TB] FAIL b2b_grant1: got %b expected 0010", s_rdy);
        end
        @(negedge clk);
        s_vld = '0;
        applyStimulus(3, 1'b0, 22'h333, 4'hF, 32'h0);
        #1;
        testsRun++;
        if (s_rdy !== 4'b1000) begin
            testsFailed++;
            $display("[TB] FAIL b2b_grant3: got %b expected 1000", s_rdy);
        end
        @(negedge clk);
        idle();
        m_rdt = 32'h11;
        #1;
        testsRun++;
        if (s_rdt !== {96'h0, 32'h11, 32'h0} || s_err !== '0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_resp1: got %h err %b expected slice1 11", s_rdt, s_err);
        end
        @(negedge clk);
        m_rdt = 32'h33;
        m_err = 1'b1;
        #1;
        testsRun++;
        if (s_rdt !== {32'h33, 96'h0} || s_err !== 4'b1000) begin
            testsFailed++;
            $display("[TB] FAIL b2b_resp3: got %h err %b expected slice3 33 err 1000", s_rdt, s_err);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_async_reset();
        doReset();
        applyStimulus(1, 1'b0, 22'h10, 4'hF, 32'h0);
        m_rdy = 1'b1;
        @(negedge clk);
        applyStimulus(2, 1'b0, 22'h20, 4'hF, 32'h0);
        m_rdy = 1'b0;
        #1;
        testsRun++;
        if (s_rdy !== '0 || m_adr !== 22'h20) begin
            testsFailed++;
            $display("[TB] FAIL ar_lock: got rdy %b adr %h expected 0000 00020", s_rdy, m_adr);
        end
        @(negedge clk);
        m_rdy = 1'b1;
        m_rdt = 32'h5555;
        m_err = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        testsRun++;
        if (m_vld !== 1'b0 || s_rdy !== '0) begin
            testsFailed++;
            $display("[TB] FAIL ar_immediate: got vld %b rdy %b expected 0 0000", m_vld, s_rdy);
        end
        testsRun++;
        if (s_rdt !== '0 || s_err !== '0) begin
            testsFailed++;
            $display("[TB] FAIL ar_flush: got rdt %h err %b expected 0", s_rdt, s_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        testsRun++;
        if (s_rdy !== 4'b0010 || s_rdt !== '0) begin
            testsFailed++;
            $display("[TB] FAIL ar_first_grant: got rdy %b rdt %h expected 0010 0", s_rdy, s_rdt);
        end
        @(negedge clk);
        s_vld[1] = 1'b0;
        #1;
        testsRun++;
        if (s_rdy !== 4'b0100 || s_rdt !== '0 || s_err !== '0) begin
            testsFailed++;
            $display("[TB] FAIL ar_second: got rdy %b rdt %h err %b expected 0100 0 0", s_rdy, s_rdt, s_err);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_random();
        logic [PN-1:0]    pend;
        logic [AW-1:0]    padr [PN];
        logic [BW-1:0]    pben [PN];
        logic [DW-1:0]    pwdt [PN];
        logic [PN-1:0]    pwen;
        resp_t            q [$];
        resp_t            r;
        int               mPtr;
        int               holder;
        int               win;
        logic             expVld;
        logic [PN-1:0]    expRdy;
        logic [PN*DW-1:0] expRdt;
        logic [PN-1:0]    expErr;
        int               errCount;
        pend = '0;
        pwen = '0;
        mPtr = 0;
        holder = -1;
        errCount = 0;
        for (int i = 0; i < PN; i++) begin
            padr[i] = '0;
            pben[i] = '0;
            pwdt[i] = '0;
        end
        doReset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < PN; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pwen[i] = 1'($urandom);
                    padr[i] = AW'($urandom);
                    pben[i] = BW'($urandom);
                    pwdt[i] = $urandom;
                end
                s_vld[i]          = pend[i];
                s_wen[i]          = pwen[i];
                s_adr[i*AW +: AW] = padr[i];
                s_ben[i*BW +: BW] = pben[i];
                s_wdt[i*DW +: DW] = pwdt[i];
            end
            m_rdy = ($urandom_range(0, 3) != 0);
            m_rdt = $urandom;
            m_err = ($urandom_range(0, 3) == 0);
            #1;
            win    = (holder >= 0) ? holder : rrPick(mPtr, pend);
            expVld = (win >= 0);
            expRdy = (expVld && m_rdy) ? PN'(1 << win) : '0;
            expRdt = '0;
            expErr = '0;
            if (q.size() > 0 && q[0].due == c) begin
                expRdt[q[0].idx*DW +: DW] = m_rdt;
                expErr[q[0].idx]          = m_err;
                void'(q.pop_front());
            end
            testsRun++;
            if (m_vld !== expVld || s_rdy !== expRdy) begin
                testsFailed++;
                errCount++;
                if (errCount < 20)
                    $display("[TB] FAIL rand_grant_c%0d: got vld %b rdy %b expected %b %b", c, m_vld, s_rdy, expVld, expRdy);
            end
            testsRun++;
            if (expVld ? (m_adr !== padr[win] || m_wen !== pwen[win] || m_ben !== pben[win] || m_wdt !== pwdt[win])
                       : (m_adr !== '0 || m_wen !== 1'b0 || m_ben !== '0 || m_wdt !== '0)) begin
                testsFailed++;
                errCount++;
                if (errCount < 20)
                    $display("[TB] FAIL rand_payload_c%0d: got adr %h wen %b ben %h wdt %h for manager %0d", c, m_adr, m_wen, m_ben, m_wdt, win);
            end
            testsRun++;
            if (s_rdt !== expRdt || s_err !== expErr) begin
                testsFailed++;
                errCount++;
                if (errCount < 20)
                    $display("[TB] FAIL rand_resp_c%0d: got rdt %h err %b expected %h %b", c, s_rdt, s_err, expRdt, expErr);
            end
            if (expVld && m_rdy) begin
                r.due = c + DLY;
                r.idx = win;
                q.push_back(r);
                pend[win] = 1'b0;
                mPtr = (win + 1) % PN;
                holder = -1;
            end else if (expVld) begin
                holder = win;
            end else begin
                holder = -1;
            end
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/tcb_arb.md
# tcb_arb

Round-robin arbiter that shares one TCB subordinate (a GPIO controller or data memory) among PN TCB managers. It sits between the managers and the subordinate-side address decoder. It forwards the winning manager's request combinationally and holds the grant until the handshake completes. It returns read data and error responses to the issuing manager after the subordinate's fixed response delay.

## Interface
Parameters:
- PN, 2: number of managers; must be ≥ 2; index width IW = $clog2(PN).
- AW, 22: address width.
- DW, 32: data width.
- BW, DW/8: byte-enable width.
- DLY, 1: subordinate response delay in cycles; must be ≥ 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- s_vld  input  PN  per-manager request valid.
- s_wen  input  PN  per-manager write enable.
- s_adr  input  PN*AW  per-manager address; manager i occupies slice [i*AW +: AW].
- s_ben  input  PN*BW  per-manager byte enables.
- s_wdt  input  PN*DW  per-manager write data.
- s_rdy  output  PN  per-manager ready.
- s_rdt  output  PN*DW  per-manager read data.
- s_err  output  PN  per-manager error.
- m_vld  output  1  subordinate request valid.
- m_wen  output  1  subordinate write enable.
- m_adr  output  AW  subordinate address.
- m_ben  output  BW  subordinate byte enables.
- m_wdt  output  DW  subordinate write data.
- m_rdy  input  1  subordinate ready.
- m_rdt  input  DW  subordinate read data.
- m_err  input  1  subordinate error.

## Operation
- Registered state:
  - ptr (IW bits): round-robin priority pointer.
  - lck (1 bit): grant locked.
  - lgn (IW bits): locked grant index.
  - Response pipeline of DLY stages, each holding {valid, idx}.
- Selection (sel):
  - If lck=1, sel=lgn.
  - Otherwise sel is the first i with s_vld[i]=1, searching ptr, ptr+1, …, PN-1, 0, …, ptr-1 (modulo PN).
  - any = |s_vld, or lck.
- Request path:
  - m_vld = any & s_vld[sel].
  - m_wen, m_adr, m_ben and m_wdt are the slices of manager sel.
  - When m_vld=0, m_wen, m_adr, m_ben and m_wdt are 0.
- Ready: s_rdy[i] = m_rdy & m_vld & (sel==i); all other managers see 0.
- Transfer: occurs in a cycle where m_vld & m_rdy.
- Lock: a cycle with m_vld=1 and m_rdy=0 sets lck=1 and lgn=sel. This prevents a grant switch while a manager holds vld (TCB rule: vld is held until rdy).
- Unlock: any transfer clears lck and sets ptr = (sel+1) mod PN.
- Protocol violation: if a locked manager drops vld without a transfer, lck clears on the next edge and ptr is unchanged.
- Response routing:
  - Stage 0 captures {transfer, sel} every cycle; the remaining stages shift.
  - The last stage {rv, ri} is aligned with m_rdt/m_err.
  - s_rdt[ri] = m_rdt and s_err[ri] = m_err when rv=1.
  - All other s_rdt slices and s_err bits are 0.
- Simultaneous events:
  - A new request may be granted in the same cycle a previous response is routed; the request and response paths are independent.
  - Back-to-back transfers from different managers are allowed every cycle.

## Timing
- Request path: combinational from s_* and m_rdy to m_* and s_rdy. There is no added request latency.
- Response path: the response for a transfer at cycle T appears on s_rdt/s_err at cycle T+DLY, identical to a direct connection.
- Throughput: one transfer per cycle.
- Fairness: a continuously requesting manager waits at most PN-1 transfers.
- Reset values (while rst=1 and after release until new requests):
  - ptr=0, lck=0, response pipeline all invalid.
  - m_vld=0, s_rdy=0 (all bits), s_rdt=0, s_err=0.
  - During rst, m_vld and s_rdy are forced to 0 regardless of s_vld.
- Reset mid-operation: a pending lock and in-flight responses are discarded. The first cycle after release arbitrates from ptr=0.

## Test plan
- Single request, PN=2, DLY=1, m_rdy=1: manager 1 reads 0x000010 and the subordinate returns 0xDEADBEEF. Required: s_rdy[1]=1 in the request cycle; s_rdt[1]=0xDEADBEEF one cycle later; s_rdt[0]=0.
- Contention, PN=4: all s_vld held high, m_rdy=1. Required grant order 0,1,2,3,0,… with one transfer per cycle and ptr wrapping after 3.
- Backpressure: manager 2 requests with m_rdy=0 for 3 cycles while manager 0 raises vld in the second cycle. Required: m_adr stays at manager 2's address; s_rdy[0]=0; manager 2 transfers on the first m_rdy=1 cycle; manager 0 is granted in the following cycle.
- Response alignment, DLY=2: back-to-back reads by managers 1 then 3 with m_rdt 0x11 then 0x33 and m_err=1 on the second. Required: s_rdt[1]=0x11 at T+2; s_rdt[3]=0x33 and s_err[3]=1 at T+3.
- Async reset: assert rst mid-lock with a transfer in flight. Required: m_vld=0 and s_rdy=0 immediately; no response is routed after release; the first grant after release goes to the lowest requesting index.
